// File: rtl/d_flipflop.sv
// d_flipflop
//   Enabled D-type register with a synchronous, active-low reset.
//   There is no path from any input to q that avoids the register.
//   A rising clk edge with rst=0 loads RESET_VALUE, whatever en and d are.
//   A rising clk edge with rst=1 and en=1 captures d.
//   A rising clk edge with rst=1 and en=0 keeps the stored value.
//
// Parameters
//   WIDTH        data width of d and q (1..64)
//   RESET_VALUE  value loaded into q while rst=0
//
// Ports
//   clk  in   1      clock; rising edge only
//   rst  in   1      synchronous reset, active low
//   en   in   1      capture enable, active high, shared by all bits
//   d    in   WIDTH  data to capture
//   q    out  WIDTH  registered data

module d_flipflop #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next value when not in reset: one enable covers the whole word.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Reset is sampled at the edge, so it overrides any pending capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_d_flipflop.sv
// Testbench for d_flipflop. It uses two instances: one with the default
// parameters (1 bit, reset to 0) and one 8 bits wide that resets to 8'hA5.
// Both instances share rst and en. The 1-bit instance receives d[0].

module tb_d_flipflop;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] d;
  logic       q1;
  logic [7:0] q8;

  d_flipflop u_dut1 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d[0]),
    .q   (q1)
  );

  d_flipflop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d),
    .q   (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       exp1;
    logic [7:0] exp8;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int edge_no = 0;
  bit drv_done = 1'b0;

  // Reference model state: the value q is expected to hold after each edge.
  logic       m1;
  logic [7:0] m8;

  // Monitor state: the value most recently confirmed at a rising edge.
  bit         have_cur = 1'b0;
  logic       cur1;
  logic [7:0] cur8;

  // Apply one cycle of inputs just after a falling edge. Compute the value
  // the register should hold after the next rising edge and queue it.
  task automatic step(input logic r, input logic e, input logic [7:0] dv);
    exp_t x;
    rst = r;
    en  = e;
    d   = dv;
    if (r == 1'b0) begin
      m1 = 1'b0;
      m8 = 8'hA5;
    end else if (e == 1'b1) begin
      m1 = dv[0];
      m8 = dv;
    end
    x.exp1 = m1;
    x.exp8 = m8;
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Rising-edge monitor: check q against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        edge_no++;
        checks++;
        if (q1 !== x.exp1) begin
          errors++;
          $display("FAIL q1_edge edge=%0d got=%b want=%b", edge_no, q1, x.exp1);
        end
        checks++;
        if (q8 !== x.exp8) begin
          errors++;
          $display("FAIL q8_edge edge=%0d got=%h want=%h", edge_no, q8, x.exp8);
        end
        cur1 = x.exp1;
        cur8 = x.exp8;
        have_cur = 1'b1;
      end
    end
  end

  // Mid-cycle monitor: inputs changed at the falling edge (rst included),
  // and q must not move until the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (have_cur && !drv_done) begin
        checks++;
        if (q1 !== cur1) begin
          errors++;
          $display("FAIL q1_midcycle edge=%0d got=%b want=%b", edge_no, q1, cur1);
        end
        checks++;
        if (q8 !== cur8) begin
          errors++;
          $display("FAIL q8_midcycle edge=%0d got=%h want=%h", edge_no, q8, cur8);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       r;
    logic       e;
    logic [7:0] dv;

    // Reset priority: rst=0 with en=1 and d=all ones, held for three edges.
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hFF);
    // Release rst with en=0: q keeps the reset value.
    step(1'b1, 1'b0, 8'hFF);
    // Capture 1, then capture 0.
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h00);
    // Hold while d toggles, then capture again.
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b1, 8'h01);
    // Drop rst in the middle of a capture run; q stays in reset while rst=0.
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h01);
    // Release rst with en=1: q takes d at the first edge.
    step(1'b1, 1'b1, 8'h01);
    // Reset again, then release with en=0.
    step(1'b0, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h01);
    // 8-bit instance: reset value, then capture 3C, then hold while d=FF.
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 8'hFF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 9) != 0);
      e  = 1'($urandom_range(0, 1));
      dv = 8'($urandom);
      step(r, e, dv);
    end

    drv_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/d_flipflop.md
D_FLIPFLOP -- requirements
Module: d_flipflop

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, setting the data width of d and q in bits (legal range 1 to 64).
REQ-002 The block SHALL have parameter RESET_VALUE, default all-zeros, setting the value loaded into q during reset; it is WIDTH bits wide.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-low reset (rst=0 resets).
REQ-005 The block SHALL have port d, input, WIDTH bits, the data to capture.
REQ-006 The block SHALL have port en, input, 1 bit, the capture enable (active-high).
REQ-007 The block SHALL have port q, output, WIDTH bits, the registered data, driven directly from the storage register.

Function
REQ-008 On each rising clk edge with rst=1 and en=1, q SHALL take the value of d sampled at that edge; latency is one cycle.
REQ-009 On each rising clk edge with rst=1 and en=0, q SHALL hold its previous value.
REQ-010 Changes on d or en between rising edges SHALL NOT affect q; there is no combinational path from any input to q.
REQ-011 en and d SHALL be ignored while rst=0; reset has priority over enable.
REQ-012 All WIDTH bits SHALL update together under one shared en; there are no per-bit enables.
REQ-013 Falling clk edges SHALL have no effect.
REQ-014 q SHALL be X/undefined in simulation only before the first rising edge with rst=0 or en=1; the design SHALL NOT rely on an initial value.

Reset
REQ-015 On a rising clk edge with rst=0, q SHALL become RESET_VALUE (default 0), regardless of en and d.
REQ-016 Asserting or deasserting rst between clock edges SHALL NOT change q; q changes only at the next rising edge.
REQ-017 On the first rising edge after rst returns to 1, normal enable/capture behaviour SHALL resume: en=1 captures d, en=0 holds RESET_VALUE.
REQ-018 Asserting reset in the middle of a run of enabled captures SHALL discard the pending capture at that edge; q SHALL become RESET_VALUE.

Verification
REQ-019 Capture: rst=1, en=1, d=1 before an edge -> q=1 after that edge; d=0 before the next edge -> q=0 after the next edge.
REQ-020 Hold: q=0, en=0, d toggled 1 then 0 across three edges -> q stays 0 throughout; then en=1, d=1 -> q=1 at the next edge.
REQ-021 Synchronous reset: q=1, en=1, d=1, rst driven 0 mid-cycle -> q stays 1 until the next rising edge, then q=0, and q stays 0 for every edge while rst=0.
REQ-022 Reset release: rst returned to 1 with en=1, d=1 -> q=1 at the first edge after release; with en=0 instead -> q stays 0.
REQ-023 Reset priority: rst=0, en=1, d=1 held for 3 edges -> q=0 after each edge.
REQ-024 Width and reset-value check: WIDTH=8, RESET_VALUE=8'hA5; reset -> q=8'hA5; then en=1, d=8'h3C -> q=8'h3C one edge later; then en=0, d=8'hFF -> q stays 8'h3C.
